// File: rtl/pipe_stage_reg_pkg.sv
// y86_pkg: shared Y86-64 status codes, instruction codes and register constants.
package y86_pkg;
    typedef enum logic [2:0] {SAOK = 3'd1, SADR = 3'd2, SINS = 3'd3, SHLT = 3'd4} stat_t;
    localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7;
    localparam logic [3:0] ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
    localparam logic [3:0] RNONE = 4'hF;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_if: incoming/outgoing fields and control of one pipeline stage register.
interface pipe_stage_if #(parameter int WORD_W = 64, parameter int REG_W = 4);
    logic [2:0] in_stat, out_stat;
    logic [3:0] in_icode, out_icode;
    logic in_Cnd, out_Cnd;
    logic [REG_W-1:0] in_dstE, in_dstM, out_dstE, out_dstM;
    logic [WORD_W-1:0] in_valA, in_valE, out_valA, out_valE;
    logic stall, bubble, conflict;
    modport master (
        output in_stat, in_icode, in_Cnd, in_dstE, in_dstM, in_valA, in_valE, stall, bubble,
        input out_stat, out_icode, out_Cnd, out_dstE, out_dstM, out_valA, out_valE, conflict
    );
    modport slave (
        input in_stat, in_icode, in_Cnd, in_dstE, in_dstM, in_valA, in_valE, stall, bubble,
        output out_stat, out_icode, out_Cnd, out_dstE, out_dstM, out_valA, out_valE, conflict
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: event counter that clears on rst and sticks at all-ones instead of wrapping.
module sat_counter #(parameter int CNT_W = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: Y86-64 stage register with stall/bubble and sticky conflict flag.
// Defining PIPE_STAGE_PERF_EN adds saturating stall/bubble event counters.
module pipe_stage_reg
    import y86_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_bubbles,
`endif
    pipe_stage_if.slave      bus
);
    // A bubble outranks a stall, so a stall+bubble request still flushes the stage.
    always_ff @(posedge clk) begin
        if (rst || bus.bubble) begin
            bus.out_stat  <= SAOK;
            bus.out_icode <= INOP;
            bus.out_Cnd   <= 1'b0;
            bus.out_dstE  <= {REG_W{1'b1}};
            bus.out_dstM  <= {REG_W{1'b1}};
            bus.out_valA  <= {WORD_W{1'b0}};
            bus.out_valE  <= {WORD_W{1'b0}};
        end else if (!bus.stall) begin
            bus.out_stat  <= bus.in_stat;
            bus.out_icode <= bus.in_icode;
            bus.out_Cnd   <= bus.in_Cnd;
            bus.out_dstE  <= bus.in_dstE;
            bus.out_dstM  <= bus.in_dstM;
            bus.out_valA  <= bus.in_valA;
            bus.out_valE  <= bus.in_valE;
        end
        if (rst) bus.conflict <= 1'b0;
        else if (bus.stall && bus.bubble) bus.conflict <= 1'b1;
    end
`ifdef PIPE_STAGE_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_stalls (
        .clk(clk), .rst(rst), .inc(bus.stall && !bus.bubble), .count(perf_stalls)
    );
    sat_counter #(.CNT_W(CNT_W)) u_bubbles (
        .clk(clk), .rst(rst), .inc(bus.bubble), .count(perf_bubbles)
    );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table plus randomized run against a behavioural model.
// Perf-counter checks are compiled only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
    localparam int WORD_W = 64, REG_W = 4, CNT_W = 3;
    logic clk = 0, rst = 0;
    always #5 clk = ~clk;
    pipe_stage_if #(.WORD_W(WORD_W), .REG_W(REG_W)) bus ();
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] perf_stalls, perf_bubbles;
`endif
    pipe_stage_reg #(.WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
`ifdef PIPE_STAGE_PERF_EN
        .perf_stalls(perf_stalls),
        .perf_bubbles(perf_bubbles),
`endif
        .bus(bus)
    );

    typedef struct {
        logic r, s, b;
        logic [2:0] stat;
        logic [3:0] icode;
        logic cnd;
        logic [3:0] de, dm;
        logic [63:0] va, ve;
        logic [2:0] x_stat;
        logic [3:0] x_icode;
        logic x_cnd;
        logic [3:0] x_de, x_dm;
        logic [63:0] x_va, x_ve;
        logic x_conf;
        int x_ps, x_pb;
    } vec_t;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, b, input logic [2:0] st, input logic [3:0] ic,
                         input logic c, input logic [3:0] de, dm, input logic [63:0] va, ve);
        rst = r; bus.stall = s; bus.bubble = b;
        bus.in_stat = st; bus.in_icode = ic; bus.in_Cnd = c;
        bus.in_dstE = de; bus.in_dstM = dm; bus.in_valA = va; bus.in_valE = ve;
        @(posedge clk); #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [3:0] ic,
                           input logic c, input logic [3:0] de, dm, input logic [63:0] va, ve,
                           input logic cf);
        chk({tag, ".stat"}, 64'(bus.out_stat), 64'(st));
        chk({tag, ".icode"}, 64'(bus.out_icode), 64'(ic));
        chk({tag, ".Cnd"}, 64'(bus.out_Cnd), 64'(c));
        chk({tag, ".dstE"}, 64'(bus.out_dstE), 64'(de));
        chk({tag, ".dstM"}, 64'(bus.out_dstM), 64'(dm));
        chk({tag, ".valA"}, bus.out_valA, va);
        chk({tag, ".valE"}, bus.out_valE, ve);
        chk({tag, ".conflict"}, 64'(bus.conflict), 64'(cf));
    endtask

    vec_t tbl[12];
    // Reference model state: the fields a stage would currently hold.
    logic [2:0] m_stat; logic [3:0] m_icode; logic m_cnd;
    logic [3:0] m_de, m_dm; logic [63:0] m_va, m_ve; logic m_conf;
    int m_ps, m_pb, maxc;

    initial begin
        maxc = (1 << CNT_W) - 1;
        tbl = '{
            '{1,0,0, 1,6,0,0,0, 64'h0,    64'h55,   1,1,0,15,15,64'h0,64'h0,0, 0,0},
            '{0,0,0, 1,3,1,2,3, 64'hAA,   64'h1234, 1,3,1,2,3,64'hAA,64'h1234,0, 0,0},
            '{0,1,0, 1,5,0,4,5, 64'hDEAD, 64'h9999, 1,3,1,2,3,64'hAA,64'h1234,0, 1,0},
            '{0,1,0, 1,5,0,4,5, 64'hDEAD, 64'h9999, 1,3,1,2,3,64'hAA,64'h1234,0, 2,0},
            '{0,1,0, 1,5,0,4,5, 64'hDEAD, 64'h9999, 1,3,1,2,3,64'hAA,64'h1234,0, 3,0},
            '{0,0,0, 1,5,0,4,5, 64'hDEAD, 64'h9999, 1,5,0,4,5,64'hDEAD,64'h9999,0, 3,0},
            '{0,0,1, 2,6,1,7,8, 64'h11,   64'h22,   1,1,0,15,15,64'h0,64'h0,0, 3,1},
            '{0,0,0, 2,6,1,7,8, 64'h11,   64'h22,   2,6,1,7,8,64'h11,64'h22,0, 3,1},
            '{0,1,1, 3,2,0,1,0, 64'h3,    64'h4,    1,1,0,15,15,64'h0,64'h0,1, 3,2},
            '{0,0,0, 3,2,0,1,0, 64'h3,    64'h4,    3,2,0,1,0,64'h3,64'h4,1, 3,2},
            '{0,1,0, 4,9,1,6,6, 64'h7,    64'h8,    3,2,0,1,0,64'h3,64'h4,1, 4,2},
            '{1,1,0, 4,9,1,6,6, 64'h7,    64'h8,    1,1,0,15,15,64'h0,64'h0,0, 0,0}
        };
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].stat, tbl[i].icode, tbl[i].cnd,
                  tbl[i].de, tbl[i].dm, tbl[i].va, tbl[i].ve);
            chk_all($sformatf("vec%0d", i), tbl[i].x_stat, tbl[i].x_icode, tbl[i].x_cnd,
                    tbl[i].x_de, tbl[i].x_dm, tbl[i].x_va, tbl[i].x_ve, tbl[i].x_conf);
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("vec%0d.perf_stalls", i), 64'(perf_stalls), 64'(tbl[i].x_ps));
            chk($sformatf("vec%0d.perf_bubbles", i), 64'(perf_bubbles), 64'(tbl[i].x_pb));
`endif
        end
        // Saturation: ten stalls in a row, counter must stop at all-ones.
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 0, 2, 7, 1, 3, 3, 64'h5, 64'h6);
            chk_all($sformatf("sat%0d", i), 1, 1, 0, 15, 15, 0, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("sat%0d.perf_stalls", i), 64'(perf_stalls), 64'(i < maxc ? i : maxc));
`endif
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_stat = 1; m_icode = 1; m_cnd = 0; m_de = '1; m_dm = '1; m_va = 0; m_ve = 0;
        m_conf = 0; m_ps = 0; m_pb = 0;
        for (int i = 0; i < 400; i++) begin
            logic r, s, b, c;
            logic [2:0] st; logic [3:0] ic, de, dm; logic [63:0] va, ve;
            r = ($urandom_range(0, 24) == 0); s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 5) == 0); c = 1'($urandom);
            st = 3'($urandom_range(1, 4)); ic = 4'($urandom); de = 4'($urandom); dm = 4'($urandom);
            va = {$urandom, $urandom}; ve = {$urandom, $urandom};
            drive(r, s, b, st, ic, c, de, dm, va, ve);
            if (r || b) begin
                m_stat = 1; m_icode = 1; m_cnd = 0; m_de = '1; m_dm = '1; m_va = 0; m_ve = 0;
            end else if (!s) begin
                m_stat = st; m_icode = ic; m_cnd = c; m_de = de; m_dm = dm; m_va = va; m_ve = ve;
            end
            m_conf = r ? 1'b0 : (m_conf | (s & b));
            m_ps = r ? 0 : (s && !b && m_ps < maxc) ? m_ps + 1 : m_ps;
            m_pb = r ? 0 : (b && m_pb < maxc) ? m_pb + 1 : m_pb;
            chk_all($sformatf("rnd%0d", i), m_stat, m_icode, m_cnd, m_de, m_dm, m_va, m_ve, m_conf);
`ifdef PIPE_STAGE_PERF_EN
            chk($sformatf("rnd%0d.perf_stalls", i), 64'(perf_stalls), 64'(m_ps));
            chk($sformatf("rnd%0d.perf_bubbles", i), 64'(perf_bubbles), 64'(m_pb));
`endif
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the Y86-64 pipeline. It is the generic successor to the per-stage registers and can be instanced at the E→M boundary or any other stage boundary. It carries status, icode, condition flag, two register IDs and two data words. It supports hold (stall), nop injection (bubble) and synchronous reset to a bubble. It also flags illegal stall+bubble requests and, optionally, counts stall and bubble events for performance analysis.

## Interface
Parameters:
- WORD_W, 64, width of data words valA/valE
- REG_W, 4, width of register IDs dstE/dstM
- CNT_W, 32, width of performance counters (used only with the perf feature)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_stat  in  3  incoming status
- in_icode  in  4  incoming instruction code
- in_Cnd  in  1  incoming condition flag
- in_dstE, in_dstM  in  REG_W  incoming destination register IDs
- in_valA, in_valE  in  WORD_W  incoming data words
- stall  in  1  hold current contents
- bubble  in  1  load a nop instead of inputs
- out_stat, out_icode, out_Cnd, out_dstE, out_dstM, out_valA, out_valE  out  as inputs  registered fields
- conflict  out  1  sticky: stall and bubble were sampled high in the same cycle
- perf_stalls, perf_bubbles  out  CNT_W  event counters (present only with PIPE_STAGE_PERF_EN)

## Operation
- Update priority at each edge: rst > bubble > stall > load.
- rst or bubble loads the nop state:
  - stat = SAOK (1)
  - icode = INOP (1)
  - Cnd = 0
  - dstE = dstM = RNONE (all ones, width REG_W)
  - valA = valE = 0
- Every field is cleared on a bubble. No field retains stale data.
- stall (without bubble): every output holds its value.
- Load (neither stall nor bubble): every output takes its in_* value.
- stall && bubble together: bubble wins and conflict is set. conflict stays at 1 until rst.
- Reset values: every data output is in the nop state; conflict = 0; both perf counters = 0.

## Timing
- Latency is 1 cycle from input to output. There is no combinational path from inputs to outputs.
- stall and bubble are sampled at the same edge as the data. A single-cycle pulse affects exactly one edge.
- rst asserted mid-stall or mid-bubble: the nop state applies on that edge, and the counters clear on that edge (rst does not count as an event).
- conflict rises on the edge after the offending cycle.

## Configuration
- PIPE_STAGE_PERF_EN defined:
  - perf_stalls increments on each edge where stall=1, bubble=0 and rst=0.
  - perf_bubbles increments on each edge where bubble=1 and rst=0, including conflict cycles.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- PIPE_STAGE_PERF_EN undefined:
  - The perf ports and counters are absent.
  - All other behaviour is identical.

## Structure
- Shared package y86_pkg holds:
  - stat codes SAOK=1, SADR=2, SINS=3, SHLT=4
  - icode constants, including INOP=1
  - the RNONE constant
- One sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, count), instanced twice under the macro.

## Test plan
- Reset: assert rst for 1 cycle with in_icode=6, in_valE=0x55. Required next cycle: out_icode=1, out_stat=1, out_dstE=out_dstM=0xF, out_valA=out_valE=0, out_Cnd=0, conflict=0.
- Load then stall:
  - Load icode=3, valE=0x1234, dstE=2, then hold stall=1 for 3 cycles while inputs change to icode=5.
  - Required: outputs stay at icode=3/valE=0x1234/dstE=2 throughout.
  - With perf enabled: perf_stalls=3.
- Bubble: with outputs holding icode=5 and valA=0xDEAD, pulse bubble. Required next cycle: full nop state, out_valA=0. On the following cycle, new inputs load normally.
- Conflict: assert stall=1 and bubble=1 for 1 cycle. Required: nop state loaded, conflict=1 and held high until rst; with perf enabled, perf_bubbles+1 and perf_stalls unchanged.
- Reset mid-stall: with stall=1 and outputs holding data, assert rst. Required: nop state loaded, counters=0, conflict=0.
- Saturation (perf build, CNT_W=3): apply 10 consecutive stalls. Required: perf_stalls reads 7 and stays at 7.
